// File: rtl/mips32_pkg.sv
// mips32_pkg: opcodes, pipeline type codes, fetch FSM encoding and default widths shared by the mips32 stages.
package mips32_pkg;

    localparam int PFQ_ADDR_W = 10;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} instr_type_e;

    typedef enum logic [1:0] {RUN, WAIT, STOP} pfq_state_e;

endpackage

// File: rtl/pfq_fifo.sv
// pfq_fifo: synchronous FIFO with flush and a registered head that shows a pushed word the cycle after its push.
module pfq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [W-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          head_valid_q, head_valid_d;

    always_comb begin
        rd_d         = flush ? '0 : rd_q + AW'(pop);
        wr_d         = flush ? '0 : wr_q + AW'(push);
        count_d      = flush ? '0 : count_q + CW'(push) - CW'(pop);
        head_valid_d = count_d != '0;
        // An entry written this edge is not yet readable from mem_q, so bypass din into an emptied head
        head_d       = !head_valid_d ? '0 :
                       ((count_q - CW'(pop)) == '0) ? din : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            if (push && !flush)
                mem_q[wr_q] <= din;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head       = head_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: mips32 fetch front end; prefetches sequential words into a FIFO and flushes on redirect.
// Define PFQ_HLT_STOP_EN to stop fetching once an HLT word has been queued.
module instr_prefetch_queue
    import mips32_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = PFQ_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic                   clk1,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_rvalid,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [DATA_W-1:0]      ir,
    output logic [31:0]            npc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;

    pfq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic              discard_q, discard_d;
    logic              outstanding, resp, issue, push, pop, hlt;
    logic [ADDR_W-1:0] head_npc;

    assign outstanding = state_q == WAIT;
    assign resp        = outstanding && mem_rvalid;
    assign issue       = !rst && state_q == RUN && !redirect_valid && count < CW'(DEPTH);
    assign push        = resp && !redirect_valid && !discard_q;
    assign pop         = ir_valid && ir_ready;

`ifdef PFQ_HLT_STOP_EN
    assign hlt = mem_rdata[31:26] == HLT;
`else
    assign hlt = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        state_d    = state_q;
        if (redirect_valid) begin
            // Only a request still in flight after this edge can return a stale word
            pc_d      = redirect_pc;
            discard_d = outstanding && !mem_rvalid;
            state_d   = discard_d ? WAIT : RUN;
        end else if (issue) begin
            pc_d       = pc_q + ADDR_W'(1);
            req_addr_d = pc_q;
            state_d    = WAIT;
        end else if (resp) begin
            discard_d = 1'b0;
            state_d   = (push && hlt) ? STOP : RUN;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    pfq_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + ADDR_W)
    ) u_fifo (
        .clk        (clk1),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .din        ({mem_rdata, req_addr_q + ADDR_W'(1)}),
        .count      (count),
        .head_valid (ir_valid),
        .head       ({ir, head_npc})
    );

    assign mem_req  = issue;
    assign mem_addr = pc_q;
    assign npc      = 32'(head_npc);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: memory model plus scoreboard of expected {ir, npc} pushed per request, checked per pop.
module tb_instr_prefetch_queue;

    logic        clk1;
    logic        rst;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] npc;
    logic [2:0]  count;

    instr_prefetch_queue #(.DEPTH(4), .ADDR_W(10), .DATA_W(32)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .npc            (npc),
        .count          (count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_req = 0;
    int          n_pop = 0;
    int          lat   = 1;
    logic [31:0] memw [1024];
    logic [63:0] sbq [$];
    logic [9:0]  exp_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Memory model and scoreboard, all sampled at the falling edge where DUT outputs are settled
    initial begin
        int          cnt;
        logic [9:0]  raddr;
        logic [9:0]  a;
        logic [63:0] e;
        cnt        = 0;
        raddr      = '0;
        exp_pc     = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk1);
            mem_rvalid = 1'b0;
            if (rst) begin
                cnt    = 0;
                exp_pc = '0;
                n_req  = 0;
                sbq.delete();
            end else begin
                if (ir_valid && ir_ready) begin
                    check("sb_nonempty", 64'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("ir", ir, e[63:32]);
                        check("npc", npc, e[31:0]);
                        n_pop++;
                    end
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = memw[raddr];
                    end
                end
                if (mem_req) begin
                    check("mem_addr", mem_addr, exp_pc);
                    n_req++;
                    a      = mem_addr;
                    raddr  = a;
                    cnt    = lat;
                    exp_pc = exp_pc + 10'd1;
                    sbq.push_back({memw[a], 22'b0, a + 10'd1});
                end
                if (redirect_valid) begin
                    sbq.delete();
                    exp_pc = redirect_pc;
                end
            end
        end
    end

    initial begin
        int p0;
        bit found;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ir_ready       = 1'b0;
        for (int i = 0; i < 1024; i++) memw[i] = 32'(i);

        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_count", count, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_npc", npc, 0);
        @(posedge clk1);
        #1 rst = 1'b0;

        // Streaming with 1-cycle memory
        ir_ready = 1'b1;
        p0 = n_pop;
        tick(40);
        check("stream_pops", 64'((n_pop - p0) >= 15), 1);

        // Backpressure: fill, then drain
        ir_ready = 1'b0;
        do_reset();
        tick(20);
        @(negedge clk1);
        check("bp_count", count, 4);
        check("bp_mem_req", mem_req, 0);
        check("bp_reqs", 64'(n_req), 4);
        check("bp_head_ir", ir, 0);
        check("bp_head_npc", npc, 1);
        @(posedge clk1);
        #1 ir_ready = 1'b1;
        tick(20);
        check("bp_resume", 64'(n_req >= 8), 1);

        // Redirect while a 3-cycle fetch of 0x005 is pending
        lat = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk1);
            found = mem_req && mem_addr == 10'h005;
        end
        check("t3_found", 64'(found), 1);
        @(posedge clk1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 10'h100;
        @(posedge clk1);
        #1 redirect_valid = 1'b0;
        @(negedge clk1);
        check("t3_count", count, 0);
        check("t3_ir_valid", ir_valid, 0);
        check("t3_hold", mem_req, 0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (k > 0) @(negedge clk1);
            found = mem_req;
        end
        check("t3_req_seen", 64'(found), 1);
        check("t3_req_addr", mem_addr, 10'h100);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk1);
            found = ir_valid;
        end
        check("t3_ir_seen", 64'(found), 1);
        check("t3_ir", ir, 32'h100);
        check("t3_npc", npc, 32'h101);

        // Redirect coinciding with a response and a pop
        lat      = 1;
        ir_ready = 1'b0;
        do_reset();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk1);
            found = count == 3'd2;
        end
        check("t4_fill", 64'(found), 1);
        @(posedge clk1);
        #1 ir_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk1);
            found = mem_req;
        end
        check("t4_req_seen", 64'(found), 1);
        @(posedge clk1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 10'h040;
        @(posedge clk1);
        #1 redirect_valid = 1'b0;
        @(negedge clk1);
        check("t4_count", count, 0);
        check("t4_ir_valid", ir_valid, 0);
        check("t4_next_req", mem_req, 1);
        check("t4_next_addr", mem_addr, 10'h040);

        // Address wrap past 1023
        do_reset();
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd1022;
        tick(1);
        redirect_valid = 1'b0;
        p0 = n_pop;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk1);
            found = ir_valid;
        end
        check("wrap_seen", 64'(found), 1);
        check("wrap_ir", ir, 32'd1022);
        check("wrap_npc", npc, 32'd1023);
        tick(16);
        check("wrap_pops", 64'((n_pop - p0) >= 3), 1);

        // HLT handling
        memw[3] = 32'hFC000000;
        do_reset();
        p0 = n_pop;
        tick(30);
        @(negedge clk1);
`ifdef PFQ_HLT_STOP_EN
        check("hlt_reqs", 64'(n_req), 4);
        check("hlt_mem_req", mem_req, 0);
        check("hlt_pops", 64'(n_pop - p0), 4);
        @(posedge clk1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 10'd8;
        tick(1);
        redirect_valid = 1'b0;
        tick(10);
        check("hlt_restart", 64'(n_req > 4), 1);
`else
        check("hlt_ignored", 64'(n_req > 4), 1);
`endif
        memw[3] = 32'd3;

        tick(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
